decoder_2x4: RTL and testbench

Registered 2-to-4 line decoder with active-high enable. Converts a 2-bit binary select into a one-hot 4-bit output, forced to all-zero when disabled. Used as a small address/select decode stage in front of 4-way enables or muxes. The output is registered on the system clock and cleared by a synchronous reset.

---
 rtl/decoder_pkg.sv | 8 +
 rtl/decoder_2x4_onehot_chk.sv | 9 +
 rtl/decoder_2x4.sv | 34 +++
 tb/tb_decoder_2x4.sv | 69 ++++++
 4 files changed

// File: rtl/decoder_pkg.sv
// decoder_pkg: shared widths, types and constants for the 2-to-4 decoder
package decoder_pkg;
  localparam int SEL_W = 2;
  localparam int OUT_W = 4;
  typedef logic [SEL_W-1:0] sel_t;
  typedef logic [OUT_W-1:0] onehot_t;
  localparam onehot_t ONEHOT_ZERO = 4'b0000;
endpackage

// File: rtl/decoder_2x4_onehot_chk.sv
// onehot_chk: combinational zero-or-one-hot detector
module onehot_chk
  import decoder_pkg::*;
(
  input  onehot_t i_vec,
  output logic    o_ok
);
  assign o_ok = ~|(i_vec & (i_vec - onehot_t'(1)));
endmodule

// File: rtl/decoder_2x4.sv
// decoder_2x4: registered 2-to-4 one-hot decoder; DECODER_2X4_ONEHOT_CHK_EN adds a sticky onehot_err flag
module decoder_2x4
  import decoder_pkg::*;
(
  input  logic    clk,
  input  logic    rst,
  input  sel_t    in,
  input  logic    en,
`ifdef DECODER_2X4_ONEHOT_CHK_EN
  output onehot_t out,
  output logic    onehot_err
`else
  output onehot_t out
`endif
);
  onehot_t r_out;
  onehot_t w_next;
  assign w_next = en ? onehot_t'(1) << in : ONEHOT_ZERO;
  always_ff @(posedge clk) begin
    if (rst) r_out <= ONEHOT_ZERO;
    else     r_out <= w_next;
  end
  assign out = r_out;
`ifdef DECODER_2X4_ONEHOT_CHK_EN
  logic w_ok;
  logic r_err;
  onehot_chk u_chk (.i_vec(r_out), .o_ok(w_ok));
  always_ff @(posedge clk) begin
    if (rst) r_err <= 1'b0;
    else     r_err <= r_err | ~w_ok;
  end
  assign onehot_err = r_err;
`endif
endmodule

// File: tb/tb_decoder_2x4.sv
// tb_decoder_2x4: directed and random self-checking bench for decoder_2x4
module tb_decoder_2x4;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] in  = 2'd0;
  logic       en  = 1'b0;
  logic [3:0] out;
  int checks = 0;
  int errors = 0;
`ifdef DECODER_2X4_ONEHOT_CHK_EN
  logic onehot_err;
  decoder_2x4 dut (.clk(clk), .rst(rst), .in(in), .en(en), .out(out), .onehot_err(onehot_err));
`else
  decoder_2x4 dut (.clk(clk), .rst(rst), .in(in), .en(en), .out(out));
`endif
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [3:0] got, input logic [3:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %b expected %b", tag, got, exp);
    end
  endtask
  task automatic cyc(input logic r, input logic e, input logic [1:0] s);
    rst = r;
    en  = e;
    in  = s;
    @(negedge clk);
  endtask
  logic [3:0] sweep [4] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
  initial begin
    @(negedge clk);
    cyc(1, 1, 3); check("rst_hold0", out, 4'b0000);
    cyc(1, 1, 3); check("rst_hold1", out, 4'b0000);
    cyc(0, 1, 3); check("rst_release", out, 4'b1000);
    for (int i = 0; i < 4; i++) begin
      cyc(0, 1, 2'(i)); check($sformatf("sweep%0d", i), out, sweep[i]);
    end
    for (int i = 0; i < 4; i++) begin
      cyc(0, 0, 2'(i)); check($sformatf("dis%0d", i), out, 4'b0000);
    end
    cyc(0, 1, 2); check("reenable", out, 4'b0100);
    for (int i = 0; i < 12; i++) begin
      logic [1:0] s;
      s = 2'($urandom_range(0, 3));
      cyc(0, 1, s);
      check($sformatf("rand%0d", i), out, 4'b0001 << s);
      check($sformatf("rand_oh%0d", i), {3'b0, $onehot(out)}, 4'b0001);
    end
    cyc(0, 1, 2); check("pre_mid_rst", out, 4'b0100);
    cyc(1, 1, 2); check("mid_rst", out, 4'b0000);
    cyc(0, 1, 1); check("post_mid_rst", out, 4'b0010);
    cyc(0, 1, 0); check("resume", out, 4'b0001);
`ifdef DECODER_2X4_ONEHOT_CHK_EN
    check("err_clean", {3'b0, onehot_err}, 4'b0000);
    en = 1'b0;
    force dut.r_out = 4'b0110;
    @(negedge clk);
    check("err_set", {3'b0, onehot_err}, 4'b0001);
    release dut.r_out;
    cyc(0, 0, 0); check("err_sticky0", {3'b0, onehot_err}, 4'b0001);
    cyc(0, 1, 3); check("err_sticky1", {3'b0, onehot_err}, 4'b0001);
    cyc(1, 1, 3); check("err_rst", {3'b0, onehot_err}, 4'b0000);
    cyc(0, 1, 3); check("err_after", {3'b0, onehot_err}, 4'b0000);
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
